program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 39 +++
 rtl/program_loader.sv | 215 +++++++++++++++++++++
 tb/tb_program_loader.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// ----------------------------------------------------------------------------
// program_loader_if
// Purpose : Groups the byte-stream handshake and the program-memory write bus
//           used by program_loader.
// Signals : byte_valid       source presents a byte
//           byte_data[7:0]   incoming stream byte
//           byte_ready       loader accepts a byte this cycle
//           mem_write_enable program-memory write strobe (one-cycle pulse)
//           mem_address      program-memory byte address (word aligned)
//           mem_write_data   program-memory write word
// Modports: master - byte source / memory side (drives the stream)
//           slave  - the loader (consumes the stream, drives the memory bus)
// ----------------------------------------------------------------------------
interface program_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_write_enable,
        input  mem_address,
        input  mem_write_data
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_write_enable,
        output mem_address,
        output mem_write_data
    );
endinterface

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
// Purpose : Receives a byte stream of the form
//             N (4 bytes, little-endian word count)
//             N words (4 bytes each, little-endian)
//             [C (1 checksum byte) when LOADER_CHECKSUM_EN is defined]
//           writes each word to program memory at byte address 4*k and holds
//           the CPU in reset until the load finishes successfully.
// Config  : `define LOADER_CHECKSUM_EN adds the CSUM state: the load succeeds
//           only if (sum of data bytes + C) mod 256 == 0.
// Ports   : clk          system clock, rising edge
//           reset_n      asynchronous active-low reset
//           start        single-cycle load request (IDLE/DONE/ERROR only)
//           bus          program_loader_if.slave (byte stream + memory bus)
//           cpu_reset_n  active-low CPU reset, high only in DONE
//           busy         high in LEN, DATA, CSUM, WRITE_LAST
//           done         high in DONE
//           error        high in ERROR
// ----------------------------------------------------------------------------
module program_loader #(
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    program_loader_if.slave  bus,
    output logic             cpu_reset_n,
    output logic             busy,
    output logic             done,
    output logic             error
);

    // Wide enough to hold MAX_WORDS itself: the counter reaches N after the
    // last word, and N <= MAX_WORDS, so it never wraps.
    localparam int unsigned WCW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        WRITE_LAST,
        DONE,
        ERROR
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [1:0]      r_byte_cnt;
    logic [WCW-1:0]  r_word_cnt;
    logic [23:0]     r_asm;       // lower three bytes of the word in flight
    logic [31:0]     r_len;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      r_csum;
    logic [7:0]      w_csum_total;
`endif

    logic            w_byte_ready;
    logic            w_accept;
    logic            w_start_ok;
    logic            w_last_byte;
    logic            w_last_word;
    logic [31:0]     w_full_word;

    assign w_accept    = bus.byte_valid && w_byte_ready;
    assign w_start_ok  = start && (r_state inside {IDLE, DONE, ERROR});
    assign w_last_byte = (r_byte_cnt == 2'd3);
    // r_asm is a right-shift register, so after three bytes it already holds
    // {b2, b1, b0}; the fourth byte completes the little-endian word.
    assign w_full_word = {bus.byte_data, r_asm};
    assign w_last_word = ((32'(r_word_cnt) + 32'd1) == r_len);
`ifdef LOADER_CHECKSUM_EN
    assign w_csum_total = r_csum + bus.byte_data;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next       = r_state;
        w_byte_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        cpu_reset_n  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) w_next = LEN;
            end

            LEN: begin
                w_byte_ready = 1'b1;
                busy         = 1'b1;
                if (w_accept && w_last_byte) begin
                    if (w_full_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        w_next = CSUM;
`else
                        w_next = DONE;
`endif
                    end else if (w_full_word > MAX_WORDS) begin
                        w_next = ERROR;
                    end else begin
                        w_next = DATA;
                    end
                end
            end

            DATA: begin
                w_byte_ready = 1'b1;
                busy         = 1'b1;
                if (w_accept && w_last_byte && w_last_word) w_next = WRITE_LAST;
            end

`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                w_byte_ready = 1'b1;
                busy         = 1'b1;
                if (w_accept) w_next = (w_csum_total == 8'd0) ? DONE : ERROR;
            end
`endif

            WRITE_LAST: begin
                busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                w_next = CSUM;
`else
                w_next = DONE;
`endif
            end

            DONE: begin
                done        = 1'b1;
                cpu_reset_n = 1'b1;
                if (start) w_next = LEN;
            end

            ERROR: begin
                error = 1'b1;
                if (start) w_next = LEN;
            end

            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: byte assembly, counters and the registered write pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_asm      <= '0;
            r_len      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_byte_cnt <= '0;
                r_word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                r_csum     <= '0;
`endif
            end else if (w_accept && (r_state inside {LEN, DATA})) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_asm      <= {bus.byte_data, r_asm[23:8]};
                if (r_state == LEN) begin
                    if (w_last_byte) r_len <= w_full_word;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    r_csum <= r_csum + bus.byte_data;
`endif
                    // Pulse lands in the following cycle while the next
                    // word keeps streaming in, so words go back-to-back.
                    if (w_last_byte) begin
                        r_we       <= 1'b1;
                        r_addr     <= 32'(r_word_cnt) << 2;
                        r_wdata    <= w_full_word;
                        r_word_cnt <= r_word_cnt + WCW'(1);
                    end
                end
            end
        end
    end

    assign bus.byte_ready       = w_byte_ready;
    assign bus.mem_write_enable = r_we;
    assign bus.mem_address      = r_addr;
    assign bus.mem_write_data   = r_wdata;

endmodule

// File: tb/tb_program_loader.sv
// ----------------------------------------------------------------------------
// tb_program_loader
// Purpose : Self-checking bench for program_loader. Table-driven and random
//           loads are compared against a stream-level reference model; a few
//           hand-written sequences cover exact timing, N=0, over-length,
//           checksum (when LOADER_CHECKSUM_EN is defined) and mid-load reset.
// ----------------------------------------------------------------------------
module tb_program_loader;

    localparam int unsigned MW = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic cpu_reset_n, busy, done, error;

    program_loader_if u_if ();

    program_loader #(.MAX_WORDS(MW)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .bus         (u_if),
        .cpu_reset_n (cpu_reset_n),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned cyc;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];
    logic [7:0] stim_q[$];

    always @(negedge clk) begin
        if (u_if.mem_write_enable === 1'b1)
            got_q.push_back('{u_if.mem_address, u_if.mem_write_data, cyc});
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents one byte (after an optional idle gap) and returns the cycle in
    // which it was accepted.
    task automatic push_byte(input logic [7:0] b, input int unsigned gap,
                             input bit with_start, output int unsigned acc_cyc);
        int unsigned t;
        u_if.byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        u_if.byte_valid = 1'b1;
        u_if.byte_data  = b;
        start           = with_start;
        t = 0;
        while (1) begin
            @(negedge clk);
            if (u_if.byte_ready === 1'b1) break;
            t++;
            if (t > 40) begin
                n_checks++;
                $display("FAIL byte_accept_timeout: byte 0x%02h never accepted", b);
                break;
            end
        end
        @(posedge clk); #1;
        acc_cyc         = cyc;
        u_if.byte_valid = 1'b0;
        start           = 1'b0;
    endtask

    // Waits (bounded) until the loader reports done or error.
    task automatic wait_finish();
        int unsigned t;
        t = 0;
        while (!(done === 1'b1 || error === 1'b1)) begin
            @(negedge clk);
            t++;
            if (t > 60) begin
                n_checks++;
                $display("FAIL finish_timeout: done=%0b error=%0b", done, error);
                break;
            end
        end
    endtask

    function automatic logic [31:0] stim_len();
        return 32'(stim_q[0]) + 32'(stim_q[1]) * 32'd256 +
               32'(stim_q[2]) * 32'd65536 + 32'(stim_q[3]) * 32'd16777216;
    endfunction

    // Builds a stream: length, 4*n random bytes (only if n fits) and, with
    // the checksum feature, a C byte that is correct unless bad is set.
    task automatic fill_stim(input logic [31:0] n, input bit bad);
        int unsigned sum;
        stim_q.delete();
        for (int unsigned j = 0; j < 4; j++) stim_q.push_back(8'((n / (32'd1 << (8 * j))) % 256));
        sum = 0;
        if (n <= MW) begin
            for (int unsigned j = 0; j < 4 * n; j++) begin
                stim_q.push_back(8'($urandom_range(0, 255)));
                sum += stim_q[stim_q.size() - 1];
            end
`ifdef LOADER_CHECKSUM_EN
            stim_q.push_back(8'((256 - (sum % 256) + (bad ? 1 : 0)) % 256));
`endif
        end
    endtask

    // Reference model: expected writes and whether the load must succeed.
    task automatic model(output bit ok);
        logic [31:0] n;
        int unsigned sum;
        exp_q.delete();
        n   = stim_len();
        ok  = (n <= MW);
        sum = 0;
        if (ok) begin
            for (int unsigned k = 0; k < n; k++) begin
                logic [31:0] w;
                w = 0;
                for (int unsigned j = 0; j < 4; j++) begin
                    w   = w + 32'(stim_q[4 + 4 * k + j]) * (32'd1 << (8 * j));
                    sum = sum + stim_q[4 + 4 * k + j];
                end
                exp_q.push_back('{32'(4 * k), w, 0});
            end
`ifdef LOADER_CHECKSUM_EN
            ok = ((sum + stim_q[4 + 4 * n]) % 256 == 0);
`endif
        end
    endtask

    task automatic compare_result(input string tag, input int unsigned exp_writes);
        bit ok;
        model(ok);
        check({tag, "_done"},        32'(done),        32'(ok));
        check({tag, "_error"},       32'(error),       32'(!ok));
        check({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'(ok));
        check({tag, "_byte_ready"},  32'(u_if.byte_ready), 32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_nwrites"},     32'(got_q.size()), 32'(exp_writes));
        check({tag, "_model_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int unsigned k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            check($sformatf("%s_addr%0d", tag, k), got_q[k].addr, exp_q[k].addr);
            check($sformatf("%s_data%0d", tag, k), got_q[k].data, exp_q[k].data);
        end
    endtask

    task automatic run_load(input string tag, input int unsigned gapmax,
                            input int start_idx, input int unsigned exp_writes);
        int unsigned acc, npush;
        got_q.delete();
        pulse_start();
        check({tag, "_start_busy"},  32'(busy),        32'd1);
        check({tag, "_start_cpurst"}, 32'(cpu_reset_n), 32'd0);
        npush = (stim_len() > MW) ? 4 : stim_q.size();
        for (int unsigned i = 0; i < npush; i++)
            push_byte(stim_q[i], (gapmax > 0) ? $urandom_range(0, gapmax) : 0,
                      (int'(i) == start_idx), acc);
        wait_finish();
        @(negedge clk);
        compare_result(tag, exp_writes);
    endtask

    typedef struct {
        logic [31:0] n;
        int unsigned gapmax;
        int          start_idx;     // byte index presented together with start
        bit          bad_csum;
        int unsigned exp_writes;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int unsigned acc, acc7, acc11;

        vecs = '{
            '{32'd1,      3, -1, 1'b0, 1},
            '{32'd3,      0,  6, 1'b0, 3},
            '{32'(MW),    1, -1, 1'b0, MW},
            '{32'd0,      0,  2, 1'b0, 0},
            '{32'(MW + 1), 0, -1, 1'b0, 0},
            '{32'd2,      2,  9, 1'b1, 2}
        };

        u_if.byte_valid = 1'b0;
        u_if.byte_data  = 8'h00;

        // Reset state.
        #1;
        check("rst_byte_ready", 32'(u_if.byte_ready),       32'd0);
        check("rst_we",         32'(u_if.mem_write_enable), 32'd0);
        check("rst_addr",       u_if.mem_address,           32'd0);
        check("rst_wdata",      u_if.mem_write_data,        32'd0);
        check("rst_cpurst",     32'(cpu_reset_n),           32'd0);
        check("rst_flags",      {29'd0, busy, done, error}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

`ifndef LOADER_CHECKSUM_EN
        // Two-word load with valid held high: exact cadence and timing.
        stim_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00};
        got_q.delete();
        pulse_start();
        acc7 = 0; acc11 = 0;
        for (int unsigned i = 0; i < 12; i++) begin
            push_byte(stim_q[i], 0, 1'b0, acc);
            if (i == 7)  acc7  = acc;
            if (i == 11) acc11 = acc;
        end
        @(negedge clk);
        check("n2_wl_done", 32'(done), 32'd0);
        check("n2_wl_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("n2_done",   32'(done),        32'd1);
        check("n2_cpurst", 32'(cpu_reset_n), 32'd1);
        check("n2_nwrites", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("n2_w0", got_q[0].data, 32'h00000513);
            check("n2_a0", got_q[0].addr, 32'h0);
            check("n2_w1", got_q[1].data, 32'h00100093);
            check("n2_a1", got_q[1].addr, 32'h4);
            check("n2_c0", got_q[0].cyc, acc7);
            check("n2_c1", got_q[1].cyc, acc11);
        end

        // N=0: DONE in the cycle right after the 4th length byte.
        stim_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        got_q.delete();
        pulse_start();
        check("n0_cpurst_drop", 32'(cpu_reset_n), 32'd0);
        for (int unsigned i = 0; i < 4; i++) push_byte(stim_q[i], 0, 1'b0, acc);
        @(negedge clk);
        check("n0_done",    32'(done),         32'd1);
        check("n0_nwrites", 32'(got_q.size()), 32'd0);
`else
        // Checksum accept and reject with fixed data.
        for (int unsigned pass = 0; pass < 2; pass++) begin
            stim_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
            if (pass == 1) stim_q[8] = 8'hF5;
            got_q.delete();
            pulse_start();
            for (int unsigned i = 0; i < 9; i++) push_byte(stim_q[i], 0, 1'b0, acc);
            wait_finish();
            @(negedge clk);
            check($sformatf("cs%0d_done", pass),  32'(done),  32'(pass == 0));
            check($sformatf("cs%0d_error", pass), 32'(error), 32'(pass == 1));
            check($sformatf("cs%0d_nwrites", pass), 32'(got_q.size()), 32'd1);
            if (got_q.size() == 1)
                check($sformatf("cs%0d_word", pass), got_q[0].data, 32'h04030201);
        end
`endif

        // Table-driven loads.
        foreach (vecs[i]) begin
            fill_stim(vecs[i].n, vecs[i].bad_csum);
            run_load($sformatf("vec%0d", i), vecs[i].gapmax, vecs[i].start_idx,
                     vecs[i].exp_writes);
        end

        // Random loads with random valid gaps.
        for (int unsigned r = 0; r < 4; r++) begin
            logic [31:0] n;
            n = 32'($urandom_range(1, MW));
            fill_stim(n, 1'b0);
            run_load($sformatf("rnd%0d", r), 3, -1, n);
        end

        // Reset during DATA after 6 data bytes, then restart.
        fill_stim(32'd2, 1'b0);
        pulse_start();
        for (int unsigned i = 0; i < 10; i++) push_byte(stim_q[i], 0, 1'b0, acc);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        got_q.delete();
        check("mid_rst_we",     32'(u_if.mem_write_enable), 32'd0);
        check("mid_rst_addr",   u_if.mem_address,           32'd0);
        check("mid_rst_ready",  32'(u_if.byte_ready),       32'd0);
        check("mid_rst_busy",   32'(busy),                  32'd0);
        check("mid_rst_cpurst", 32'(cpu_reset_n),           32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_nowrite", 32'(got_q.size()), 32'd0);
        fill_stim(32'd1, 1'b0);
        run_load("after_rst", 0, -1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
